// File: rtl/elevator_control.sv
// Five-floor collective elevator controller.
// It latches button requests, tracks the car floor and drives the motor enable and direction with a dwell at served floors.
//
// state | meaning
// IDLE  | parked, no motion, waiting for a request
// UP    | travelling upward
// DOWN  | travelling downward
// STOP  | dwelling at a served floor for DWELL_CYCLES cycles
module elevator_control #(
    parameter int DWELL_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] floor_sensors,
    input  logic [4:0] request_buttons,
    input  logic [4:0] elevator_buttons,
    output logic       dir,
    output logic       move
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2,
        STOP = 2'd3
    } state_t;

    localparam int CNT_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL_CYCLES - 1);

    state_t           state, state_next;
    logic [2:0]       cur_floor, cur_floor_next;
    logic [4:0]       pending, pending_next;
    logic [4:0]       floor_mask, clr;
    logic             above, below, here;
    logic             dir_r, dir_next;
    logic [CNT_W-1:0] dwell_cnt, dwell_next;

    // Only a clean one-hot sensor pattern moves the floor estimate.
    always_comb begin
        cur_floor_next = cur_floor;
        case (floor_sensors)
            5'b00001: cur_floor_next = 3'd0;
            5'b00010: cur_floor_next = 3'd1;
            5'b00100: cur_floor_next = 3'd2;
            5'b01000: cur_floor_next = 3'd3;
            5'b10000: cur_floor_next = 3'd4;
            default:  cur_floor_next = cur_floor;
        endcase
    end

    always_comb begin
        floor_mask = 5'(5'b00001 << cur_floor);
        here       = |(pending & floor_mask);
        above      = 1'b0;
        below      = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (pending[i] && (3'(i) > cur_floor)) above = 1'b1;
            if (pending[i] && (3'(i) < cur_floor)) below = 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        dir_next   = dir_r;
        dwell_next = dwell_cnt;
        case (state)
            IDLE: begin
                if (here)       state_next = STOP;
                else if (above) state_next = UP;
                else if (below) state_next = DOWN;
            end
            UP: begin
                if (here)       state_next = STOP;
                else if (above) state_next = UP;
                else if (below) state_next = DOWN;
                else            state_next = IDLE;
            end
            DOWN: begin
                if (here)       state_next = STOP;
                else if (below) state_next = DOWN;
                else if (above) state_next = UP;
                else            state_next = IDLE;
            end
            STOP: begin
                if (dwell_cnt != '0)        dwell_next = dwell_cnt - CNT_W'(1);
                else if (dir_r && above)    state_next = UP;
                else if (!dir_r && below)   state_next = DOWN;
                else if (above)             state_next = UP;
                else if (below)             state_next = DOWN;
                else                        state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase

        // Never drive past the end floors, whatever the request picture says.
        if (state_next == UP && cur_floor == 3'd4)   state_next = IDLE;
        if (state_next == DOWN && cur_floor == 3'd0) state_next = IDLE;

        if (state_next == UP)   dir_next = 1'b1;
        if (state_next == DOWN) dir_next = 1'b0;
        if (state_next == STOP && state != STOP) dwell_next = DWELL_LOAD;
    end

    // The served floor's request is cleared for the whole dwell, so re-presses are absorbed.
    always_comb begin
        clr          = (state_next == STOP || state == STOP) ? floor_mask : 5'b00000;
        pending_next = (pending | request_buttons | elevator_buttons) & ~clr;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cur_floor <= 3'd0;
            pending   <= 5'b00000;
            dir_r     <= 1'b1;
            dwell_cnt <= '0;
        end else begin
            state     <= state_next;
            cur_floor <= cur_floor_next;
            pending   <= pending_next;
            dir_r     <= dir_next;
            dwell_cnt <= dwell_next;
        end
    end

    assign move = (state == UP) || (state == DOWN);
    assign dir  = dir_r;

endmodule

// File: tb/tb_elevator_control.sv
// Scripted scenarios for elevator_control; each driven cycle queues the expected {move, dir}
// after the sampling edge, which is popped and compared once that edge has passed.
module tb_elevator_control;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] floor_sensors;
    logic [4:0] request_buttons;
    logic [4:0] elevator_buttons;
    logic       dir;
    logic       move;

    typedef struct {
        logic [1:0] out;
        string      tag;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    elevator_control #(.DWELL_CYCLES(4)) dut (
        .clk              (clk),
        .reset            (reset),
        .floor_sensors    (floor_sensors),
        .request_buttons  (request_buttons),
        .elevator_buttons (elevator_buttons),
        .dir              (dir),
        .move             (move)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [1:0] got, input logic [1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: move/dir got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic tick(input logic rst, input logic [4:0] s, input logic [4:0] r,
                        input logic [4:0] e, input logic em, input logic ed, input string tag);
        exp_t ex;
        reset            = rst;
        floor_sensors    = s;
        request_buttons  = r;
        elevator_buttons = e;
        sb.push_back('{out: {em, ed}, tag: tag});
        @(posedge clk);
        #1;
        ex = sb.pop_front();
        check_val(ex.tag, {move, dir}, ex.out);
    endtask

    task automatic hold(input logic [4:0] s, input int n, input logic em, input logic ed,
                        input string tag);
        for (int k = 0; k < n; k++) tick(1'b0, s, 5'b0, 5'b0, em, ed, tag);
    endtask

    initial begin
        reset            = 1'b1;
        floor_sensors    = 5'b0;
        request_buttons  = 5'b0;
        elevator_buttons = 5'b0;

        // Reset and quiet idle at floor 0
        for (int k = 0; k < 5; k++) tick(1'b1, 5'b00000, 5'b0, 5'b0, 1'b0, 1'b1, "reset");
        hold(5'b00001, 2, 1'b0, 1'b1, "idle_quiet");

        // Floor 0 -> 1 on a hall call
        tick(1'b0, 5'b00001, 5'b00010, 5'b0, 1'b0, 1'b1, "a_latch");
        tick(1'b0, 5'b00001, 5'b0, 5'b0, 1'b1, 1'b1, "a_depart");
        hold(5'b00000, 1, 1'b1, 1'b1, "a_travel");
        hold(5'b00010, 1, 1'b1, 1'b1, "a_arrive");
        hold(5'b00010, 4, 1'b0, 1'b1, "a_dwell");
        hold(5'b00010, 2, 1'b0, 1'b1, "a_idle");

        // Re-serve floor 1 from the car panel, hall call to 4 arrives while stopped
        tick(1'b0, 5'b00010, 5'b0, 5'b00010, 1'b0, 1'b1, "b_latch_here");
        tick(1'b0, 5'b00010, 5'b10000, 5'b0, 1'b0, 1'b1, "b_stop_entry");
        hold(5'b00010, 3, 1'b0, 1'b1, "b_dwell");
        hold(5'b00010, 1, 1'b1, 1'b1, "b_depart_up");
        hold(5'b00000, 1, 1'b1, 1'b1, "b_travel");
        hold(5'b00100, 2, 1'b1, 1'b1, "b_pass_f2");
        hold(5'b00000, 1, 1'b1, 1'b1, "b_travel");
        hold(5'b01000, 2, 1'b1, 1'b1, "b_pass_f3");
        hold(5'b00000, 1, 1'b1, 1'b1, "b_travel");
        hold(5'b10000, 1, 1'b1, 1'b1, "b_arrive_f4");
        hold(5'b10000, 4, 1'b0, 1'b1, "b_dwell_f4");
        hold(5'b10000, 1, 1'b0, 1'b1, "b_idle_f4");

        // Current-floor press while idle: dwell, then the request is gone
        tick(1'b0, 5'b10000, 5'b0, 5'b10000, 1'b0, 1'b1, "c_latch_here");
        hold(5'b10000, 4, 1'b0, 1'b1, "c_dwell");
        hold(5'b10000, 2, 1'b0, 1'b1, "c_cleared");

        // Floor 4 -> 0 from the car panel
        tick(1'b0, 5'b10000, 5'b0, 5'b00001, 1'b0, 1'b1, "d_latch");
        hold(5'b10000, 1, 1'b1, 1'b0, "d_depart_down");
        hold(5'b00000, 1, 1'b1, 1'b0, "d_travel");
        hold(5'b01000, 1, 1'b1, 1'b0, "d_pass_f3");
        hold(5'b00100, 1, 1'b1, 1'b0, "d_pass_f2");
        hold(5'b00010, 1, 1'b1, 1'b0, "d_pass_f1");
        hold(5'b00001, 1, 1'b1, 1'b0, "d_arrive_f0");
        hold(5'b00001, 4, 1'b0, 1'b0, "d_dwell");
        hold(5'b00001, 1, 1'b0, 1'b0, "d_idle_dir_held");

        // Up from 1 with 3 pending, 0 requested during the dwell at 1
        tick(1'b0, 5'b00001, 5'b0, 5'b01010, 1'b0, 1'b0, "e_latch");
        hold(5'b00001, 1, 1'b1, 1'b1, "e_depart_up");
        hold(5'b00000, 1, 1'b1, 1'b1, "e_travel");
        hold(5'b00010, 1, 1'b1, 1'b1, "e_arrive_f1");
        hold(5'b00010, 1, 1'b0, 1'b1, "e_stop_f1");
        tick(1'b0, 5'b00010, 5'b00001, 5'b0, 1'b0, 1'b1, "e_call_during_stop");
        hold(5'b00010, 2, 1'b0, 1'b1, "e_dwell_f1");
        hold(5'b00010, 1, 1'b1, 1'b1, "e_keep_up");
        hold(5'b00000, 1, 1'b1, 1'b1, "e_travel");
        hold(5'b00100, 2, 1'b1, 1'b1, "e_pass_f2_up");
        hold(5'b00000, 1, 1'b1, 1'b1, "e_travel");
        hold(5'b01000, 1, 1'b1, 1'b1, "e_arrive_f3");
        hold(5'b01000, 4, 1'b0, 1'b1, "e_dwell_f3");
        hold(5'b01000, 1, 1'b1, 1'b0, "e_reverse_down");
        hold(5'b00000, 1, 1'b1, 1'b0, "e_travel");
        hold(5'b00100, 2, 1'b1, 1'b0, "e_pass_f2_down");
        hold(5'b00110, 1, 1'b1, 1'b0, "e_multihot");
        hold(5'b00000, 1, 1'b1, 1'b0, "e_travel");
        hold(5'b00010, 1, 1'b1, 1'b0, "e_pass_f1");
        hold(5'b00000, 1, 1'b1, 1'b0, "e_travel");
        hold(5'b00001, 1, 1'b1, 1'b0, "e_arrive_f0");
        hold(5'b00001, 4, 1'b0, 1'b0, "e_dwell_f0");
        hold(5'b00001, 1, 1'b0, 1'b0, "e_idle");

        // Requests above and below from floor 2: up wins; then reset mid-travel
        hold(5'b00100, 1, 1'b0, 1'b0, "f_resync_f2");
        tick(1'b0, 5'b00100, 5'b10001, 5'b0, 1'b0, 1'b0, "f_latch_both");
        hold(5'b00100, 1, 1'b1, 1'b1, "f_up_wins");
        hold(5'b00000, 1, 1'b1, 1'b1, "f_travel");
        tick(1'b1, 5'b00000, 5'b0, 5'b0, 1'b0, 1'b1, "f_reset_mid");
        hold(5'b00000, 2, 1'b0, 1'b1, "f_pending_lost");

        check_val("sb_empty", 2'(sb.size()), 2'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
